// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode/state enums and iteration count for iter_muldiv
package muldiv_pkg;
  localparam int ITER = 8;
  typedef enum logic [1:0] {MULLO = 2'b00, MULHI = 2'b01, DIV = 2'b10, MOD = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_e;
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative shift-add multiply / restoring divide unit (Start/Op/OperandA/OperandB/DestAddr in; Busy/Done/DivZero/WriteEn/Waddr/WrData registered out)
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = ITER,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  OperandA,
  input  logic [WIDTH-1:0]  OperandB,
  input  logic [ADDR_W-1:0] DestAddr,
  output logic              Busy,
  output logic              Done,
  output logic              DivZero,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] Waddr,
  output logic [WIDTH-1:0]  WrData
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e state, state_n;
  op_e op_q;
  logic [WIDTH-1:0] a_q, b_q, quo, quo_n, rem, rem_n, res, wd_n;
  logic [ADDR_W-1:0] dest_q, waddr_n;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH:0] sum, pr;
  logic [CW-1:0] cnt;
  logic last, ge, busy_n, done_n, dz_n;
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod[0]}} & a_q};
    prod_n = {sum, prod[WIDTH-1:1]};
    pr = {rem, quo[WIDTH-1]};
    ge = pr >= {1'b0, b_q};
    rem_n = ge ? pr[WIDTH-1:0] - b_q : pr[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
    res = op_q == MULLO ? prod_n[WIDTH-1:0] :
          op_q == MULHI ? prod_n[2*WIDTH-1:WIDTH] :
          op_q == DIV   ? quo_n : rem_n;
    last = cnt == CW'(WIDTH - 1);
  end
  always_comb begin
    state_n = state;
    busy_n = 1'b0;
    done_n = 1'b0;
    dz_n = 1'b0;
    waddr_n = '0;
    wd_n = '0;
    case (state)
      IDLE: if (Start) begin
        state_n = RUN;
        busy_n = 1'b1;
      end
      RUN: begin
        busy_n = 1'b1;
        if (last) begin
          state_n = WRITE;
          done_n = 1'b1;
          waddr_n = dest_q;
          wd_n = res;
          dz_n = (op_q == DIV || op_q == MOD) && b_q == '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      WriteEn <= 1'b0;
      DivZero <= 1'b0;
      Waddr <= '0;
      WrData <= '0;
    end else begin
      state <= state_n;
      Busy <= busy_n;
      Done <= done_n;
      WriteEn <= done_n;
      DivZero <= dz_n;
      Waddr <= waddr_n;
      WrData <= wd_n;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q <= MULLO;
      a_q <= '0;
      b_q <= '0;
      dest_q <= '0;
      prod <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else if (state == IDLE && Start) begin
      op_q <= op_e'(Op);
      a_q <= OperandA;
      b_q <= OperandB;
      dest_q <= DestAddr;
      prod <= {{WIDTH{1'b0}}, OperandB};
      rem <= '0;
      quo <= OperandA;
      cnt <= '0;
    end else if (state == RUN) begin
      prod <= prod_n;
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: table-driven scoreboard bench for iter_muldiv
module tb_iter_muldiv;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] dest = '0;
  logic busy, done, dz, we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  int cmp = 0, bad = 0;
  typedef struct {logic [1:0] op; logic [7:0] a; logic [7:0] b; logic [2:0] d; logic [7:0] r; logic z;} vec_t;
  typedef struct {logic [2:0] d; logic [7:0] r; logic z;} exp_t;
  exp_t sb[$];
  vec_t vecs[14];
  iter_muldiv dut (
    .Clk(clk), .Reset(rst), .Start(start), .Op(op), .OperandA(a), .OperandB(b), .DestAddr(dest),
    .Busy(busy), .Done(done), .DivZero(dz), .WriteEn(we), .Waddr(waddr), .WrData(wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v, input int poke);
    exp_t e;
    int cyc;
    sb.push_back('{v.d, v.r, v.z});
    op = v.op; a = v.a; b = v.b; dest = v.d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); dest = 3'($urandom);
    cyc = 1;
    chk("busy_c1", int'(busy), 1);
    while (!done && cyc < 20) begin
      start = cyc == poke;
      if (cyc == poke) op = 2'b10;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("latency", cyc, 9);
    chk("we", int'(we), 1);
    chk("busy_wr", int'(busy), 1);
    chk("waddr", int'(waddr), int'(e.d));
    chk("wdata", int'(wdata), int'(e.r));
    chk("divzero", int'(dz), int'(e.z));
    @(negedge clk);
    chk("done_fall", int'(done), 0);
    chk("we_fall", int'(we), 0);
    chk("dz_fall", int'(dz), 0);
    chk("wdata_idle", int'(wdata), 0);
    chk("waddr_idle", int'(waddr), 0);
    chk("busy_idle", int'(busy), 0);
  endtask
  initial begin
    int nwr;
    vecs[0]  = '{2'd0, 8'h0D, 8'h0B, 3'd3, 8'h8F, 1'b0};
    vecs[1]  = '{2'd1, 8'hC8, 8'hC8, 3'd1, 8'h9C, 1'b0};
    vecs[2]  = '{2'd0, 8'hC8, 8'hC8, 3'd2, 8'h40, 1'b0};
    vecs[3]  = '{2'd2, 8'hC8, 8'h07, 3'd4, 8'h1C, 1'b0};
    vecs[4]  = '{2'd3, 8'hC8, 8'h07, 3'd5, 8'h04, 1'b0};
    vecs[5]  = '{2'd2, 8'hFF, 8'h01, 3'd6, 8'hFF, 1'b0};
    vecs[6]  = '{2'd3, 8'hFF, 8'h01, 3'd7, 8'h00, 1'b0};
    vecs[7]  = '{2'd2, 8'h55, 8'h00, 3'd0, 8'hFF, 1'b1};
    vecs[8]  = '{2'd3, 8'h55, 8'h00, 3'd1, 8'h55, 1'b1};
    vecs[9]  = '{2'd1, 8'hFF, 8'hFF, 3'd2, 8'hFE, 1'b0};
    vecs[10] = '{2'd2, 8'h07, 8'hC8, 3'd3, 8'h00, 1'b0};
    vecs[11] = '{2'd3, 8'h07, 8'hC8, 3'd4, 8'h07, 1'b0};
    vecs[12] = '{2'd0, 8'h55, 8'h00, 3'd5, 8'h00, 1'b0};
    vecs[13] = '{2'd1, 8'h0D, 8'h0B, 3'd6, 8'h00, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_dz", int'(dz), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run_op(vecs[i], 0);
    run_op(vecs[0], 4);
    nwr = 0;
    repeat (12) begin
      @(negedge clk);
      nwr += int'(we);
    end
    chk("no_queued_write", nwr, 0);
    op = 2'd0; a = 8'h0D; b = 8'h0B; dest = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_wdata", int'(wdata), 0);
    nwr = 0;
    repeat (15) begin
      @(negedge clk);
      nwr += int'(we);
    end
    chk("mid_rst_no_write", nwr, 0);
    run_op(vecs[3], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
